// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the MEM/WB stream shares one write port with a FIFO of
// long-unit (mul/div) results. A starvation limit forces a long write and stalls MEM/WB.
module wb_port_arbiter #(
    parameter int DATA_W     = 64,
    parameter int REG_W      = 5,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pipe_valid,
    input  logic [REG_W-1:0]            pipe_regD,
    input  logic [DATA_W-1:0]           pipe_data,
    output logic                        pipe_stall,
    input  logic                        long_valid,
    output logic                        long_ready,
    input  logic [REG_W-1:0]            long_regD,
    input  logic [DATA_W-1:0]           long_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        rf_we,
    output logic [REG_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]           rf_wdata
);

    localparam int PTR_W    = $clog2(LQ_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [REG_W-1:0]    lq_addr_r [LQ_DEPTH];
    logic [DATA_W-1:0]   lq_data_r [LQ_DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    lq_count_r;
    logic [STARVE_W-1:0] starve_r;
    logic [STARVE_W-1:0] starve_nxt_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic                rf_we_r;
    logic [REG_W-1:0]    rf_waddr_r;
    logic [DATA_W-1:0]   rf_wdata_r;

    logic pipe_req_s;
    logic long_ready_s;
    logic long_grant_s;
    logic pipe_grant_s;
    logic enq_s;
    logic lq_empty_s;

    // Request qualification and grant decision, all from registered FIFO state
    always_comb begin
        pipe_req_s   = pipe_valid & (pipe_regD != {REG_W{1'b0}});
        lq_empty_s   = (lq_count_r == {CNT_W{1'b0}});
        long_ready_s = reset & (lq_count_r < CNT_W'(LQ_DEPTH));
        long_grant_s = reset & ~lq_empty_s &
                       (~pipe_req_s | (starve_r == STARVE_W'(STARVE_MAX)));
        pipe_grant_s = reset & pipe_req_s & ~long_grant_s;
        enq_s        = long_valid & long_ready_s & (long_regD != {REG_W{1'b0}});
    end

    // Next occupancy and starvation count
    always_comb begin
        count_nxt_s  = lq_count_r;
        starve_nxt_s = starve_r;
        case ({enq_s, long_grant_s})
            2'b10:   count_nxt_s = lq_count_r + CNT_W'(1);
            2'b01:   count_nxt_s = lq_count_r - CNT_W'(1);
            default: count_nxt_s = lq_count_r;
        endcase
        if (long_grant_s || lq_empty_s) begin
            starve_nxt_s = {STARVE_W{1'b0}};
        end else if (pipe_grant_s && (starve_r != STARVE_W'(STARVE_MAX))) begin
            starve_nxt_s = starve_r + STARVE_W'(1);
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // FIFO storage; stale slots are never read because occupancy gates every dequeue
    always_ff @(posedge clk) begin
        if (enq_s) begin
            lq_addr_r[tail_r] <= long_regD;
            lq_data_r[tail_r] <= long_data;
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            lq_count_r <= {CNT_W{1'b0}};
            starve_r   <= {STARVE_W{1'b0}};
        end else begin
            if (long_grant_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (enq_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            lq_count_r <= count_nxt_s;
            starve_r   <= starve_nxt_s;
        end
    end

    // Registered write port; address/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {REG_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
        end else if (long_grant_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= lq_addr_r[head_r];
            rf_wdata_r <= lq_data_r[head_r];
        end else if (pipe_grant_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= pipe_regD;
            rf_wdata_r <= pipe_data;
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

    assign pipe_stall = pipe_req_s & long_grant_s;
    assign long_ready = long_ready_s;
    assign lq_count   = lq_count_r;
    assign rf_we      = rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference of the arbitration rules.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_regD;
    logic [63:0] pipe_data;
    logic        pipe_stall;
    logic        long_valid;
    logic        long_ready;
    logic [4:0]  long_regD;
    logic [63:0] long_data;
    logic [1:0]  lq_count;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    wb_port_arbiter #(.DATA_W(64), .REG_W(5), .LQ_DEPTH(2), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_regD(pipe_regD), .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .long_valid(long_valid), .long_ready(long_ready), .long_regD(long_regD),
        .long_data(long_data), .lq_count(lq_count),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve_m;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    int          checks;
    int          failures;
    logic        obs_stall;
    logic        obs_ready;
    logic        exp_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, with the reference applied to the same inputs
    task automatic step(input logic rst, input logic pv, input logic [4:0] prd,
                        input logic [63:0] pd, input logic lv, input logic [4:0] lrd,
                        input logic [63:0] ld);
        bit   preq, rdy, lg, pg;
        int   sz;
        ent_t e;
        @(negedge clk);
        reset = rst; pipe_valid = pv; pipe_regD = prd; pipe_data = pd;
        long_valid = lv; long_regD = lrd; long_data = ld;
        #1;
        sz   = q.size();
        preq = pv && (prd != 5'd0);
        rdy  = rst && (sz < 2);
        lg   = rst && (sz != 0) && (!preq || starve_m == 3);
        pg   = rst && preq && !lg;
        exp_stall = preq && lg;
        obs_stall = pipe_stall;
        obs_ready = long_ready;
        chk("pipe_stall", {63'd0, pipe_stall}, {63'd0, exp_stall});
        chk("long_ready", {63'd0, long_ready}, {63'd0, rdy});
        @(posedge clk);
        if (!rst) begin
            q.delete();
            starve_m = 0;
            m_we = 1'b0; m_addr = 5'd0; m_data = 64'd0;
        end else begin
            if (lg) begin
                m_we = 1'b1; m_addr = q[0].a; m_data = q[0].d;
                void'(q.pop_front());
            end else if (pg) begin
                m_we = 1'b1; m_addr = prd; m_data = pd;
            end else begin
                m_we = 1'b0;
            end
            if (lg || sz == 0) starve_m = 0;
            else if (pg) starve_m = (starve_m < 3) ? starve_m + 1 : 3;
            if (lv && rdy && lrd != 5'd0) begin
                e.a = lrd; e.d = ld;
                q.push_back(e);
            end
        end
        #1;
        chk("rf_we",    {63'd0, rf_we},    {63'd0, m_we});
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_addr});
        chk("rf_wdata", rf_wdata,          m_data);
        chk("lq_count", {62'd0, lq_count}, 64'(q.size()));
    endtask

    initial begin
        logic        pv;
        logic [4:0]  prd;
        logic [63:0] pd;
        checks = 0; failures = 0; starve_m = 0;
        m_we = 1'b0; m_addr = 5'd0; m_data = 64'd0;
        reset = 1'b0; pipe_valid = 1'b0; pipe_regD = 5'd0; pipe_data = 64'd0;
        long_valid = 1'b0; long_regD = 5'd0; long_data = 64'd0;

        // Reset held with a long result offered
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h55);
        chk("t1_ready_in_reset", {63'd0, obs_ready}, 64'd0);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h55);
        chk("t1_we", {63'd0, rf_we}, 64'd0);
        chk("t1_count", {62'd0, lq_count}, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("t1_ready_after", {63'd0, obs_ready}, 64'd1);

        // Simple pipe write
        step(1'b1, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        chk("t2_stall", {63'd0, obs_stall}, 64'd0);
        chk("t2_we", {63'd0, rf_we}, 64'd1);
        chk("t2_addr", {59'd0, rf_waddr}, 64'd5);
        chk("t2_data", rf_wdata, 64'h1234);

        // Long result through the FIFO with pipe idle
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA);
        chk("t3_we_n1", {63'd0, rf_we}, 64'd0);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("t3_we", {63'd0, rf_we}, 64'd1);
        chk("t3_addr", {59'd0, rf_waddr}, 64'd7);
        chk("t3_data", rf_wdata, 64'hAA);
        chk("t3_count", {62'd0, lq_count}, 64'd0);

        // Starvation: one entry queued, pipe busy every cycle, data held while stalled
        step(1'b1, 1'b1, 5'd9, 64'h100, 1'b1, 5'd12, 64'hC0FFEE);
        pd = 64'h101;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 5'd9, pd, 1'b0, 5'd0, 64'd0);
            chk("t4_stall", {63'd0, obs_stall}, (i == 3) ? 64'd1 : 64'd0);
            chk("t4_addr", {59'd0, rf_waddr}, (i == 3) ? 64'd12 : 64'd9);
            if (!obs_stall) pd = pd + 64'd1;
        end

        // Full FIFO with pipe busy, then a forced dequeue frees a slot a cycle later
        step(1'b1, 1'b1, 5'd4, 64'h200, 1'b1, 5'd1, 64'hA1);
        step(1'b1, 1'b1, 5'd4, 64'h201, 1'b1, 5'd2, 64'hA2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 5'd4, 64'h300 + 64'(i), 1'b1, 5'd3, 64'hA3);
            chk("t5_ready", {63'd0, obs_ready}, (i == 3) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        // Writes to register 0 are dropped on both streams
        step(1'b1, 1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd0, 64'hBEEF);
        chk("t6_we", {63'd0, rf_we}, 64'd0);
        chk("t6_count", {62'd0, lq_count}, 64'd0);
        step(1'b1, 1'b1, 5'd6, 64'h600, 1'b1, 5'd10, 64'hB0);
        step(1'b1, 1'b1, 5'd6, 64'h601, 1'b1, 5'd11, 64'hB1);
        chk("t6_count_full", {62'd0, lq_count}, 64'd2);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        chk("t6_count_rst", {62'd0, lq_count}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
            chk("t6_no_stale", {63'd0, rf_we}, 64'd0);
        end

        // Randomized traffic; MEM/WB holds its inputs while stalled
        pv = 1'b0; prd = 5'd0; pd = 64'd0;
        for (int i = 0; i < 400; i++) begin
            if (!exp_stall) begin
                pv  = ($urandom_range(0, 3) != 0);
                prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pd  = {$urandom, $urandom};
            end
            step(($urandom_range(0, 59) != 0), pv, prd, pd,
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
